// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd
//   Iterative double-dabble binary-to-BCD converter. It sits between the
//   sequential multiplier and the display digit muxes. A start pulse captures
//   the magnitude and its sign. The magnitude is converted one bit per clock,
//   so a conversion takes BIN_W iterations. A one-cycle done pulse marks the
//   edge on which bcd, sign_out and digit_blank update. Those outputs hold
//   steady between completions, so the display never sees a partial result.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     defined   -> digit_blank is registered with bcd. Digits above the most
//                  significant non-zero digit are flagged; digit 0 is never
//                  flagged.
//     undefined -> digit_blank is tied to zero.
//
//   Ports
//     clk         system clock, rising edge
//     rst         asynchronous reset, active low
//     start       conversion request (ignored while busy)
//     bin         unsigned magnitude, sampled only on the accepting edge
//     sign_in     sign of the operand, 1 = negative
//     busy        conversion in progress
//     done        one-cycle pulse; outputs updated on this edge
//     bcd         packed BCD result, digit 0 in [3:0]
//     sign_out    captured sign, forced to 0 for a zero result
//     digit_blank per-digit leading-zero blank mask
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one add-3/shift iteration per clock, BIN_W iterations
//   DONE  | done pulse cycle; a start here is accepted back-to-back
module seq_bin_to_bcd #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  sign_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign_out,
  output logic [DIGITS-1:0]     digit_blank
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [BIN_W-1:0]      operand, operand_nxt;
  logic [4*DIGITS-1:0]   scratch, scratch_adj, scratch_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  sign_lat;
  logic                  load;
  logic                  last_iter;

  assign load      = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == SHIFT) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The add-3 correction is confined to each 4-bit digit. A digit of 5..9
  // becomes 8..12, which still fits in 4 bits, so nothing carries across.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_nxt = {scratch_adj[4*DIGITS-2:0], operand[BIN_W-1]};
    operand_nxt = {operand[BIN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      operand  <= '0;
      scratch  <= '0;
      cnt      <= '0;
      sign_lat <= 1'b0;
      bcd      <= '0;
      sign_out <= 1'b0;
    end else if (load) begin
      operand  <= bin;
      scratch  <= '0;
      cnt      <= '0;
      // Fold the zero test in at capture so that -0 is never displayed.
      sign_lat <= sign_in & (|bin);
    end else if (state == SHIFT) begin
      operand <= operand_nxt;
      scratch <= scratch_nxt;
      cnt     <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        bcd      <= scratch_nxt;
        sign_out <= sign_lat;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_nxt, blank_q;

  // Scan from the top digit down. A digit is blanked until the first
  // non-zero digit is seen. Digit 0 is left unblanked so zero shows as "0".
  always_comb begin
    logic seen;
    seen      = 1'b0;
    blank_nxt = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scratch_nxt[4*i +: 4] != 4'd0) seen = 1'b1;
      blank_nxt[i] = ~seen;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           blank_q <= '0;
    else if (last_iter) blank_q <= blank_nxt;
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
module tb_seq_bin_to_bcd;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [BIN_W-1:0]    bin = '0;
  logic                sign_in = 1'b0;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                sign_out;
  logic [DIGITS-1:0]   digit_blank;

  int checks = 0;
  int errors = 0;

  seq_bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .sign_in(sign_in),
    .busy(busy), .done(done), .bcd(bcd), .sign_out(sign_out),
    .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  // Drive a start for one edge (E0). Returns 1 ns after E0.
  task automatic start_conv(input logic [BIN_W-1:0] b, input logic s);
    start   = 1'b1;
    bin     = b;
    sign_in = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen 1 ns after an edge, bounded at 40.
  // Also count how many post-edge samples had busy high before done.
  task automatic wait_done(output int n, output int busy_cnt);
    n        = 0;
    busy_cnt = busy ? 1 : 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0 || sign_out !== 1'b0 || digit_blank !== 5'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b bcd=%h sign=%b blank=%b expected all zero",
               busy, done, bcd, sign_out, digit_blank);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int n, bc;
    logic [DIGITS-1:0] exp_blank;
`ifdef LEADING_ZERO_BLANK_EN
    exp_blank = 5'b11110;
`else
    exp_blank = 5'b00000;
`endif
    start_conv(16'd0, 1'b1);
    wait_done(n, bc);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL zero_latency got %0d expected 16", n); end
    checks++;
    if (bcd !== 20'h00000) begin errors++; $display("FAIL zero_bcd got %h expected 00000", bcd); end
    checks++;
    if (sign_out !== 1'b0) begin errors++; $display("FAIL zero_sign got %b expected 0", sign_out); end
    checks++;
    if (digit_blank !== exp_blank) begin errors++; $display("FAIL zero_blank got %b expected %b", digit_blank, exp_blank); end
    @(posedge clk); #1;
  endtask

  task automatic test_negative();
    int n, bc;
    start_conv(16'd16129, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL neg_busy_start got %b expected 1", busy); end
    wait_done(n, bc);
    checks++;
    if (bc !== 16) begin errors++; $display("FAIL neg_busy_cycles got %0d expected 16", bc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL neg_busy_at_done got %b expected 0", busy); end
    checks++;
    if (bcd !== 20'h16129 || sign_out !== 1'b1) begin
      errors++; $display("FAIL neg_result got bcd=%h sign=%b expected 16129 sign=1", bcd, sign_out);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL neg_done_width got %b expected 0", done); end
    checks++;
    if (bcd !== 20'h16129) begin errors++; $display("FAIL neg_hold got %h expected 16129", bcd); end
  endtask

  task automatic test_back_to_back();
    int n, bc;
    logic [DIGITS-1:0] exp_blank;
`ifdef LEADING_ZERO_BLANK_EN
    exp_blank = 5'b11100;
`else
    exp_blank = 5'b00000;
`endif
    start_conv(16'd65535, 1'b0);
    wait_done(n, bc);
    checks++;
    if (bcd !== 20'h65535 || sign_out !== 1'b0) begin
      errors++; $display("FAIL max_result got bcd=%h sign=%b expected 65535 sign=0", bcd, sign_out);
    end
    checks++;
    if (digit_blank !== 5'b00000) begin errors++; $display("FAIL max_blank got %b expected 00000", digit_blank); end
    // Still in the DONE cycle: accept the next operand immediately.
    start_conv(16'd42, 1'b0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got done=%b busy=%b expected done=0 busy=1", done, busy);
    end
    wait_done(n, bc);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL b2b_latency got %0d expected 16", n); end
    checks++;
    if (bcd !== 20'h00042) begin errors++; $display("FAIL b2b_bcd got %h expected 00042", bcd); end
    checks++;
    if (digit_blank !== exp_blank) begin errors++; $display("FAIL b2b_blank got %b expected %b", digit_blank, exp_blank); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int n, bc;
    start_conv(16'd1000, 1'b0);
    bin = 16'h5A5A;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; bin = 16'd7; sign_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = 16'hABCD;
    checks++;
    if (bcd !== 20'h00042) begin errors++; $display("FAIL busy_hold got %h expected 00042", bcd); end
    wait_done(n, bc);
    checks++;
    if (n !== 11) begin errors++; $display("FAIL ignore_latency got %0d expected 11", n); end
    checks++;
    if (bcd !== 20'h01000 || sign_out !== 1'b0) begin
      errors++; $display("FAIL ignore_result got bcd=%h sign=%b expected 01000 sign=0", bcd, sign_out);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    int n, bc;
    int seen_done;
    start_conv(16'd9999, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bcd !== 20'h0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state got busy=%b bcd=%h done=%b expected 0 0 0", busy, bcd, done);
    end
    seen_done = 0;
    repeat (20) begin @(posedge clk); #1; if (done) seen_done++; end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses expected 0", seen_done); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    start_conv(16'd9999, 1'b1);
    wait_done(n, bc);
    checks++;
    if (n !== 16 || bcd !== 20'h09999 || sign_out !== 1'b1) begin
      errors++; $display("FAIL abort_recover got n=%0d bcd=%h sign=%b expected 16 09999 1", n, bcd, sign_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int n, bc;
    int v;
    logic [BIN_W-1:0] b;
    logic s;
    logic [4*DIGITS-1:0] exp_bcd;
    logic digit_bad;
    for (int k = 0; k < 1000; k++) begin
      b = BIN_W'($urandom_range(0, 65535));
      if (k == 0) b = 16'd9;
      if (k == 1) b = 16'd10;
      if (k == 2) b = 16'd59999;
      s = 1'($urandom_range(0, 1));
      v = int'(b);
      exp_bcd = '0;
      for (int d = 0; d < DIGITS; d++) begin
        exp_bcd[4*d +: 4] = 4'(v % 10);
        v = v / 10;
      end
      start_conv(b, s);
      wait_done(n, bc);
      digit_bad = 1'b0;
      for (int d = 0; d < DIGITS; d++)
        if (bcd[4*d +: 4] > 4'd9) digit_bad = 1'b1;
      checks++;
      if (digit_bad !== 1'b0) begin errors++; $display("FAIL sweep_digit_range bin=%0d got %h", b, bcd); end
      checks++;
      if (n !== 16 || bcd !== exp_bcd || sign_out !== (s && b != 0)) begin
        errors++;
        $display("FAIL sweep_value bin=%0d n=%0d got bcd=%h sign=%b expected %h sign=%b",
                 b, n, bcd, sign_out, exp_bcd, (s && b != 0));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_negative();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bin_to_bcd.md
Name: seq_bin_to_bcd

Overview:
Iterative double-dabble converter placed between the sequential multiplier and the display digit muxes.
- On a start pulse it captures the multiplier's 16-bit magnitude product and its sign.
- It converts the magnitude to packed BCD, one bit per clock, and raises a one-cycle done pulse.
- The BCD result and sign are held stable for the digit-select muxes and the 7-segment driver until the next conversion completes.

Parameters:
- BIN_W, 16: width of the binary magnitude input.
- DIGITS, 5: number of BCD digits produced. The 4*DIGITS-bit output must hold 2^BIN_W-1, so 5 digits covers 65535.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, sampled on the rising edge of clk.
- bin  input  BIN_W  unsigned magnitude to convert (multiplier product).
- sign_in  input  1  sign of the product; 1 means negative.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd and sign_out are updated.
- bcd  output  4*DIGITS  packed BCD result; digit 0 is in [3:0].
- sign_out  output  1  sign captured with the operand; forced to 0 when the result is zero.
- digit_blank  output  DIGITS  per-digit leading-zero blank mask (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, bcd=0, sign_out=0, digit_blank=0.
  - Internal shift register and bit counter cleared.
  - Reset asserted mid-conversion aborts it with no done pulse; bcd returns to 0.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Load bin into the operand shift register, clear the BCD scratch register, latch sign_in, counter=0.
  - Go to SHIFT; busy=1 from this edge.
- SHIFT, each clock (one iteration):
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, operand} shifts left by 1.
  - counter increments.
- SHIFT, on the iteration with counter == BIN_W-1:
  - Copy the post-shift scratch into bcd.
  - sign_out = latched sign AND (bin != 0).
  - Go to DONE; busy=0, done=1.
- DONE (one cycle):
  - done=1; then done=0 at the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- Latency: start sampled at edge E0 → done high from edge E0+BIN_W to E0+BIN_W+1. Throughput is one conversion per BIN_W+1 clocks.
- start while in SHIFT is ignored: no restart, no queueing.
- bin and sign_in are sampled only at the accepting edge; later changes have no effect.
- bcd and sign_out change only on the completion edge, so the display never shows partial results.
- Arithmetic:
  - The +3 correction is applied to 4-bit digits and cannot carry across digits.
  - The top digit never exceeds 6 for BIN_W=16.
  - Every output digit is in the range 0..9.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - At the completion edge, digit_blank[i]=1 for each digit i above the most significant non-zero digit.
  - digit_blank[0] is always 0, so a result of 0 displays as a single "0".
  - digit_blank is registered with bcd; it resets to 0 and holds between conversions.
- Not defined: digit_blank is tied to all zeros and no extra logic is generated.

Test Plan:
1. Reset, then start with bin=0, sign_in=1 → done pulse exactly 16 clocks after the start edge; bcd=20'h00000, sign_out=0; digit_blank=5'b11110 with macro.
2. start with bin=16'd16129 (127*127), sign_in=1 → bcd=20'h16129, sign_out=1, busy high for 16 cycles, done high for exactly 1 cycle.
3. start with bin=16'd65535 → bcd=20'h65535. Then bin=16'd42 accepted in the DONE cycle (back-to-back) → bcd=20'h00042 16 clocks later; digit_blank=5'b11100 with macro.
4. start with bin=16'd1000; pulse start with bin=16'd7 at cycle 5 of SHIFT → ignored; result bcd=20'h01000; bin toggling mid-conversion has no effect.
5. Drive rst low at cycle 8 of a conversion of bin=16'd9999 → immediately busy=0, bcd=0, no done pulse. After release, a new start with bin=16'd9999 → bcd=20'h09999.
6. Random sweep of 1000 values of bin → each bcd digit is in 0..9, and the decimal value of bcd equals bin.
